// File: rtl/keyboard_encoder.sv
// Keyboard encoder: turns an 8-bit level key-state vector into PS/2 set-2
// style make/break scancode sequences over a valid/ready byte stream.
// Bits 0..3 are plain keys, bits 4..7 are extended (E0-prefixed) keys.
module keyboard_encoder #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] kb_in,
  output logic [7:0] code_out,
  output logic       code_valid_out,
  input  logic       code_ready_in,
  output logic       busy_out
);

  // Key bit positions within kb_in
  localparam logic [2:0] KbForward    = 3'd0;
  localparam logic [2:0] KbBackward   = 3'd1;
  localparam logic [2:0] KbTurnLeft   = 3'd2;
  localparam logic [2:0] KbTurnRight  = 3'd3;
  localparam logic [2:0] KbTransUp    = 3'd4;
  localparam logic [2:0] KbTransDown  = 3'd5;
  localparam logic [2:0] KbTransLeft  = 3'd6;
  localparam logic [2:0] KbTransRight = 3'd7;

  localparam logic [7:0] PrefixExt   = 8'hE0;
  localparam logic [7:0] PrefixBreak = 8'hF0;

  // Counter reload: the GAP state lasts exactly GAP_CYCLES cycles.
  localparam logic [7:0] GapLoad = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [2:0] {
    StIdle,
    StSendE0,
    StSendF0,
    StSendCode,
    StGap
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] sent_q, sent_d;
  logic [2:0] idx_q, idx_d;
  logic       make_q, make_d;
  logic [7:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic [7:0] gap_q, gap_d;

  logic [7:0] pending;
  logic [2:0] sel_idx;
  logic       sel_any;
  logic       xfer;

  // Scancode for each key position
  function automatic logic [7:0] code_of(input logic [2:0] idx);
    logic [7:0] c;
    c = 8'h00;
    unique case (idx)
      KbForward:    c = 8'h1D;
      KbBackward:   c = 8'h1B;
      KbTurnLeft:   c = 8'h1C;
      KbTurnRight:  c = 8'h23;
      KbTransUp:    c = 8'h75;
      KbTransDown:  c = 8'h72;
      KbTransLeft:  c = 8'h6B;
      KbTransRight: c = 8'h74;
      default:      c = 8'h00;
    endcase
    return c;
  endfunction

  // Extended keys occupy the upper half of kb_in
  function automatic logic is_ext(input logic [2:0] idx);
    return idx[2];
  endfunction

  // Pending keys and lowest-index priority select
  always_comb begin
    pending = kb_in ^ sent_q;
    sel_any = |pending;
    sel_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx = 3'(i);
      end
    end
  end

  assign xfer = valid_q & code_ready_in;

  // Next-state logic: sequence sequencing and output byte loading
  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    idx_d   = idx_q;
    make_d  = make_q;
    code_d  = code_q;
    valid_d = valid_q;
    gap_d   = gap_q;

    unique case (state_q)
      StIdle: begin
        if (sel_any) begin
          idx_d   = sel_idx;
          make_d  = kb_in[sel_idx];
          valid_d = 1'b1;
          if (is_ext(sel_idx)) begin
            state_d = StSendE0;
            code_d  = PrefixExt;
          end else if (!kb_in[sel_idx]) begin
            state_d = StSendF0;
            code_d  = PrefixBreak;
          end else begin
            state_d = StSendCode;
            code_d  = code_of(sel_idx);
          end
        end
      end

      StSendE0: begin
        if (xfer) begin
          if (!make_q) begin
            state_d = StSendF0;
            code_d  = PrefixBreak;
          end else begin
            state_d = StSendCode;
            code_d  = code_of(idx_q);
          end
        end
      end

      StSendF0: begin
        if (xfer) begin
          state_d = StSendCode;
          code_d  = code_of(idx_q);
        end
      end

      StSendCode: begin
        if (xfer) begin
          valid_d       = 1'b0;
          code_d        = 8'h00;
          // Commit only once the whole sequence has been accepted
          sent_d[idx_q] = make_q;
          if (GAP_CYCLES > 0) begin
            state_d = StGap;
            gap_d   = GapLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StGap: begin
        if (gap_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end

      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        code_d  = 8'h00;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence in flight
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      sent_q  <= 8'h00;
      idx_q   <= 3'd0;
      make_q  <= 1'b0;
      code_q  <= 8'h00;
      valid_q <= 1'b0;
      gap_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      idx_q   <= idx_d;
      make_q  <= make_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      gap_q   <= gap_d;
    end
  end

  assign code_out       = code_q;
  assign code_valid_out = valid_q;
  assign busy_out       = (state_q != StIdle);

endmodule

// File: tb/tb_keyboard_encoder.sv
// Directed bench for keyboard_encoder: one instance with no gap, one with
// a three-cycle gap. Outputs are sampled 1 time unit after each rising edge.
module tb_keyboard_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kb0 = 8'h00;
  logic       rdy0 = 1'b1;
  logic [7:0] code0;
  logic       valid0;
  logic       busy0;
  logic [7:0] kb3 = 8'h00;
  logic       rdy3 = 1'b1;
  logic [7:0] code3;
  logic       valid3;
  logic       busy3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keyboard_encoder #(.GAP_CYCLES(0)) dut0 (
    .clk_in         (clk),
    .rst_in         (rst),
    .kb_in          (kb0),
    .code_out       (code0),
    .code_valid_out (valid0),
    .code_ready_in  (rdy0),
    .busy_out       (busy0)
  );

  keyboard_encoder #(.GAP_CYCLES(3)) dut3 (
    .clk_in         (clk),
    .rst_in         (rst),
    .kb_in          (kb3),
    .code_out       (code3),
    .code_valid_out (valid3),
    .code_ready_in  (rdy3),
    .busy_out       (busy3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare {busy, valid, code} of the no-gap instance
  task automatic o0(input string tag, input logic b, input logic v, input logic [7:0] c);
    checks++;
    assert ({busy0, valid0, code0} === {b, v, c})
    else begin
      errors++;
      $error("FAIL %s: observed busy=%0b valid=%0b code=%02h expected busy=%0b valid=%0b code=%02h",
             tag, busy0, valid0, code0, b, v, c);
    end
  endtask

  // Same for the gap instance
  task automatic o3(input string tag, input logic b, input logic v, input logic [7:0] c);
    checks++;
    assert ({busy3, valid3, code3} === {b, v, c})
    else begin
      errors++;
      $error("FAIL %s: observed busy=%0b valid=%0b code=%02h expected busy=%0b valid=%0b code=%02h",
             tag, busy3, valid3, code3, b, v, c);
    end
  endtask

  initial begin
    #1;
    o0("reset0", 1'b0, 1'b0, 8'h00);
    o3("reset3", 1'b0, 1'b0, 8'h00);
    step();
    step();
    rst = 1'b0;

    // Plain make/break on FORWARD
    kb0 = 8'h01;
    step(); o0("fwd_make", 1'b1, 1'b1, 8'h1D);
    step(); o0("fwd_make_end", 1'b0, 1'b0, 8'h00);
    kb0 = 8'h00;
    step(); o0("fwd_brk_f0", 1'b1, 1'b1, 8'hF0);
    step(); o0("fwd_brk_code", 1'b1, 1'b1, 8'h1D);
    step(); o0("fwd_brk_end", 1'b0, 1'b0, 8'h00);

    // Extended make/break on TRANS_UP
    kb0 = 8'h10;
    step(); o0("up_make_e0", 1'b1, 1'b1, 8'hE0);
    step(); o0("up_make_code", 1'b1, 1'b1, 8'h75);
    step(); o0("up_make_end", 1'b0, 1'b0, 8'h00);
    kb0 = 8'h00;
    step(); o0("up_brk_e0", 1'b1, 1'b1, 8'hE0);
    step(); o0("up_brk_f0", 1'b1, 1'b1, 8'hF0);
    step(); o0("up_brk_code", 1'b1, 1'b1, 8'h75);
    step(); o0("up_brk_end", 1'b0, 1'b0, 8'h00);

    // TURN_RIGHT break under back-pressure
    kb0 = 8'h08;
    step(); o0("tr_make", 1'b1, 1'b1, 8'h23);
    step(); o0("tr_make_end", 1'b0, 1'b0, 8'h00);
    kb0 = 8'h00;
    rdy0 = 1'b0;
    step(); o0("tr_brk_f0_a", 1'b1, 1'b1, 8'hF0);
    step(); o0("tr_brk_f0_b", 1'b1, 1'b1, 8'hF0);
    step(); o0("tr_brk_f0_c", 1'b1, 1'b1, 8'hF0);
    rdy0 = 1'b1;
    step(); o0("tr_brk_code_a", 1'b1, 1'b1, 8'h23);
    rdy0 = 1'b0;
    step(); o0("tr_brk_code_b", 1'b1, 1'b1, 8'h23);
    step(); o0("tr_brk_code_c", 1'b1, 1'b1, 8'h23);
    rdy0 = 1'b1;
    step(); o0("tr_brk_end", 1'b0, 1'b0, 8'h00);
    step(); o0("tr_no_dup", 1'b0, 1'b0, 8'h00);

    // FORWARD + TRANS_LEFT together, BACKWARD pulse in between
    kb0 = 8'h41;
    step(); o0("pri_fwd", 1'b1, 1'b1, 8'h1D);
    kb0 = 8'h43;
    step(); o0("pri_fwd_end", 1'b0, 1'b0, 8'h00);
    step(); o0("pulse_bk_make", 1'b1, 1'b1, 8'h1B);
    kb0 = 8'h41;
    step(); o0("pulse_bk_make_end", 1'b0, 1'b0, 8'h00);
    step(); o0("pulse_bk_brk_f0", 1'b1, 1'b1, 8'hF0);
    step(); o0("pulse_bk_brk_code", 1'b1, 1'b1, 8'h1B);
    step(); o0("pulse_bk_brk_end", 1'b0, 1'b0, 8'h00);
    step(); o0("pri_tl_e0", 1'b1, 1'b1, 8'hE0);
    step(); o0("pri_tl_code", 1'b1, 1'b1, 8'h6B);
    step(); o0("pri_tl_end", 1'b0, 1'b0, 8'h00);
    kb0 = 8'h00;
    step(); o0("rel_fwd_f0", 1'b1, 1'b1, 8'hF0);
    step(); o0("rel_fwd_code", 1'b1, 1'b1, 8'h1D);
    step(); o0("rel_fwd_end", 1'b0, 1'b0, 8'h00);
    step(); o0("rel_tl_e0", 1'b1, 1'b1, 8'hE0);
    step(); o0("rel_tl_f0", 1'b1, 1'b1, 8'hF0);
    step(); o0("rel_tl_code", 1'b1, 1'b1, 8'h6B);
    step(); o0("rel_tl_end", 1'b0, 1'b0, 8'h00);

    // Reset mid-sequence on TRANS_RIGHT make
    kb0 = 8'h80;
    step(); o0("rst_seq_e0", 1'b1, 1'b1, 8'hE0);
    step(); o0("rst_seq_code", 1'b1, 1'b1, 8'h74);
    rst = 1'b1;
    #1;
    o0("rst_async_clear", 1'b0, 1'b0, 8'h00);
    step(); o0("rst_hold", 1'b0, 1'b0, 8'h00);
    step();
    rst = 1'b0;
    step(); o0("rst_reemit_e0", 1'b1, 1'b1, 8'hE0);
    step(); o0("rst_reemit_code", 1'b1, 1'b1, 8'h74);
    step(); o0("rst_reemit_end", 1'b0, 1'b0, 8'h00);

    // Three-cycle gap between two sequences
    kb3 = 8'h03;
    step(); o3("gap_fwd", 1'b1, 1'b1, 8'h1D);
    step(); o3("gap_c1", 1'b1, 1'b0, 8'h00);
    step(); o3("gap_c2", 1'b1, 1'b0, 8'h00);
    step(); o3("gap_c3", 1'b1, 1'b0, 8'h00);
    step(); o3("gap_idle", 1'b0, 1'b0, 8'h00);
    step(); o3("gap_bk", 1'b1, 1'b1, 8'h1B);
    step(); o3("gap_bk_end", 1'b1, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
